// File: rtl/uart_tx_if.sv
// Byte-request handshake and serial-line status bundle for uart_tx.
interface uart_tx_if;
   logic       i_TX_DV;
   logic [7:0] i_TX_Byte;
   logic       o_TX_Ready;
   logic       o_TX_Serial;
   logic       o_TX_Active;
   logic       o_TX_Done;

   modport master (
      output i_TX_DV, i_TX_Byte,
      input  o_TX_Ready, o_TX_Serial, o_TX_Active, o_TX_Done
   );

   modport slave (
      input  i_TX_DV, i_TX_Byte,
      output o_TX_Ready, o_TX_Serial, o_TX_Active, o_TX_Done
   );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: 8N1/8N2 framing, one byte held at a time, LSB first.
// Serial line is registered; its next value is decided alongside the next state.
module uart_tx #(
   parameter int unsigned CLKS_PER_BIT = 217,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic      i_Clock,
   input  logic      i_Reset_n,
   uart_tx_if.slave  tx
);

   localparam int unsigned CNT_W = $clog2(STOP_BITS * CLKS_PER_BIT + 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS * CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      IDLE         = 3'd0,
      TX_START_BIT = 3'd1,
      TX_DATA_BITS = 3'd2,
      TX_STOP_BIT  = 3'd3,
      CLEANUP      = 3'd4
   } state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_count;
   logic [2:0]       r_bit_idx;
   logic [7:0]       r_byte;
   logic             r_serial;

   state_t           w_state_next;
   logic [CNT_W-1:0] w_count_next;
   logic [2:0]       w_bit_next;
   logic [7:0]       w_byte_next;
   logic             w_serial_next;

   always_ff @(posedge i_Clock) begin
      if (!i_Reset_n) begin
         r_state   <= IDLE;
         r_count   <= '0;
         r_bit_idx <= '0;
         r_byte    <= '0;
         r_serial  <= 1'b1;
      end else begin
         r_state   <= w_state_next;
         r_count   <= w_count_next;
         r_bit_idx <= w_bit_next;
         r_byte    <= w_byte_next;
         r_serial  <= w_serial_next;
      end
   end

   always_comb begin
      w_state_next  = r_state;
      w_count_next  = r_count;
      w_bit_next    = r_bit_idx;
      w_byte_next   = r_byte;
      w_serial_next = 1'b1;
      case (r_state)
         IDLE: begin
            if (tx.i_TX_DV) begin
               w_byte_next   = tx.i_TX_Byte;
               w_state_next  = TX_START_BIT;
               w_count_next  = '0;
               w_bit_next    = '0;
               w_serial_next = 1'b0;
            end
         end
         TX_START_BIT: begin
            w_serial_next = 1'b0;
            if (r_count == BIT_LAST) begin
               w_count_next  = '0;
               w_bit_next    = '0;
               w_state_next  = TX_DATA_BITS;
               w_serial_next = r_byte[0];
            end else begin
               w_count_next = r_count + CNT_W'(1);
            end
         end
         TX_DATA_BITS: begin
            w_serial_next = r_byte[r_bit_idx];
            if (r_count == BIT_LAST) begin
               w_count_next = '0;
               if (r_bit_idx == 3'd7) begin
                  w_state_next  = TX_STOP_BIT;
                  w_serial_next = 1'b1;
               end else begin
                  w_bit_next    = r_bit_idx + 3'd1;
                  w_serial_next = r_byte[w_bit_next];
               end
            end else begin
               w_count_next = r_count + CNT_W'(1);
            end
         end
         TX_STOP_BIT: begin
            if (r_count == STOP_LAST) begin
               w_count_next = '0;
               w_state_next = CLEANUP;
            end else begin
               w_count_next = r_count + CNT_W'(1);
            end
         end
         CLEANUP: begin
            w_state_next = IDLE;
         end
         default: begin
            w_state_next = IDLE;
            w_count_next = '0;
            w_bit_next   = '0;
         end
      endcase
   end

   assign tx.o_TX_Serial = r_serial;
   assign tx.o_TX_Ready  = (r_state == IDLE);
   assign tx.o_TX_Done   = (r_state == CLEANUP);
   assign tx.o_TX_Active = (r_state == TX_START_BIT) || (r_state == TX_DATA_BITS) ||
                           (r_state == TX_STOP_BIT);

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: two instances (4 clk/bit 1 stop, 217 clk/bit 2 stop) checked
// cycle-by-cycle against a frame-position model fed from a byte scoreboard.
module tb_uart_tx;

   logic clk = 1'b0;
   logic rst4_n, rst217_n;
   always #5 clk = ~clk;

   uart_tx_if if4();
   uart_tx_if if217();

   uart_tx #(.CLKS_PER_BIT(4), .STOP_BITS(1)) dut4 (
      .i_Clock(clk), .i_Reset_n(rst4_n), .tx(if4.slave)
   );
   uart_tx #(.CLKS_PER_BIT(217), .STOP_BITS(2)) dut217 (
      .i_Clock(clk), .i_Reset_n(rst217_n), .tx(if217.slave)
   );

   int n_vec = 0;
   int n_err = 0;
   logic [7:0] q4[$];
   logic [7:0] q217[$];

   // Expected {serial, ready, active, done} at position k of a frame (k<0: idle).
   function automatic logic [3:0] exp_out(int k, int c, int s, logic [7:0] b);
      if (k < 0)             return 4'b1100;
      if (k == (9 + s) * c)  return 4'b1001;
      if (k < c)             return 4'b0010;
      if (k < 9 * c)         return {b[k / c - 1], 3'b010};
      return 4'b1010;
   endfunction

   int         k4 = -1;
   bit         v4 = 1'b0;
   logic [7:0] b4 = '0;
   logic [3:0] e4, g4;
   always @(negedge clk) begin
      if (v4) begin
         e4 = exp_out(k4, 4, 1, b4);
         g4 = {if4.o_TX_Serial, if4.o_TX_Ready, if4.o_TX_Active, if4.o_TX_Done};
         n_vec++;
         if (g4 !== e4) begin
            n_err++;
            $display("FAIL line4 t=%0t k=%0d {serial,ready,active,done} got=%b exp=%b",
                     $time, k4, g4, e4);
         end
      end
      if (!rst4_n) begin
         k4 = -1;
         v4 = 1'b1;
      end else if (v4) begin
         if (k4 < 0) begin
            if (if4.i_TX_DV) begin
               n_vec++;
               if (q4.size() == 0) begin
                  n_err++;
                  $display("FAIL accept4 t=%0t got=unexpected accept exp=no request", $time);
                  b4 = if4.i_TX_Byte;
               end else begin
                  b4 = q4.pop_front();
               end
               k4 = 0;
            end
         end else if (k4 == 40) begin
            k4 = -1;
         end else begin
            k4++;
         end
      end
   end

   int         k217 = -1;
   bit         v217 = 1'b0;
   logic [7:0] b217 = '0;
   logic [3:0] e217, g217;
   always @(negedge clk) begin
      if (v217) begin
         e217 = exp_out(k217, 217, 2, b217);
         g217 = {if217.o_TX_Serial, if217.o_TX_Ready, if217.o_TX_Active, if217.o_TX_Done};
         n_vec++;
         if (g217 !== e217) begin
            n_err++;
            $display("FAIL line217 t=%0t k=%0d {serial,ready,active,done} got=%b exp=%b",
                     $time, k217, g217, e217);
         end
      end
      if (!rst217_n) begin
         k217 = -1;
         v217 = 1'b1;
      end else if (v217) begin
         if (k217 < 0) begin
            if (if217.i_TX_DV) begin
               n_vec++;
               if (q217.size() == 0) begin
                  n_err++;
                  $display("FAIL accept217 t=%0t got=unexpected accept exp=no request", $time);
                  b217 = if217.i_TX_Byte;
               end else begin
                  b217 = q217.pop_front();
               end
               k217 = 0;
            end
         end else if (k217 == 2387) begin
            k217 = -1;
         end else begin
            k217++;
         end
      end
   end

   task automatic set_in(input int which, input logic dv, input logic [7:0] b);
      if (which == 0) begin
         if4.i_TX_DV = dv;
         if4.i_TX_Byte = b;
      end else begin
         if217.i_TX_DV = dv;
         if217.i_TX_Byte = b;
      end
   endtask

   task automatic push(input int which, input logic [7:0] b);
      if (which == 0) q4.push_back(b);
      else q217.push_back(b);
   endtask

   // Waits for ready, scrambling the idle byte input every cycle meanwhile.
   task automatic wait_ready(input int which, input int budget);
      logic r;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk);
         #1;
         r = (which == 0) ? if4.o_TX_Ready : if217.o_TX_Ready;
         if (r === 1'b1) return;
         set_in(which, 1'b0, 8'($urandom));
      end
      n_vec++;
      n_err++;
      $display("FAIL ready_timeout%0d t=%0t got=ready low exp=ready within %0d cycles",
               which, $time, budget);
   endtask

   task automatic send(input int which, input logic [7:0] b);
      wait_ready(which, (which == 0) ? 200 : 3000);
      set_in(which, 1'b1, b);
      push(which, b);
      @(posedge clk);
      #1;
      set_in(which, 1'b0, 8'($urandom));
   endtask

   initial begin
      rst4_n   = 1'b0;
      rst217_n = 1'b0;
      set_in(0, 1'b1, 8'h99);
      set_in(1, 1'b0, 8'h00);
      repeat (3) @(posedge clk);
      #1;
      rst4_n   = 1'b1;
      rst217_n = 1'b1;
      set_in(0, 1'b0, 8'h00);

      send(0, 8'h55);

      send(0, 8'hA3);
      repeat (10) @(posedge clk);
      #1;
      set_in(0, 1'b1, 8'hFF);
      repeat (2) @(posedge clk);
      #1;
      set_in(0, 1'b0, 8'h00);

      wait_ready(0, 200);
      set_in(0, 1'b1, 8'h01);
      push(0, 8'h01);
      @(posedge clk);
      #1;
      set_in(0, 1'b1, 8'h80);
      push(0, 8'h80);
      for (int i = 0; i < 200; i++) begin
         @(posedge clk);
         #1;
         if (if4.o_TX_Ready === 1'b1) break;
      end
      @(posedge clk);
      #1;
      set_in(0, 1'b0, 8'h00);

      send(0, 8'h96);
      repeat (17) @(posedge clk);
      #1;
      rst4_n = 1'b0;
      @(posedge clk);
      #1;
      rst4_n = 1'b1;
      send(0, 8'h3C);

      send(0, 8'hC6);
      for (int n = 0; n < 16; n++) begin
         send(0, 8'($urandom));
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
      end
      wait_ready(0, 200);

      send(1, 8'h00);
      send(1, 8'($urandom));
      wait_ready(1, 3000);
      repeat (3) @(posedge clk);
      #1;

      n_vec++;
      if (q4.size() != 0) begin
         n_err++;
         $display("FAIL queue4_empty got=%0d pending exp=0", q4.size());
      end
      n_vec++;
      if (q217.size() != 0) begin
         n_err++;
         $display("FAIL queue217_empty got=%0d pending exp=0", q217.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The module SHALL have parameter CLKS_PER_BIT, default 217, giving clock cycles per serial bit (legal range 2..65535).
REQ-002 The module SHALL have parameter STOP_BITS, default 1, giving the stop-bit count (legal values 1 or 2).
REQ-003 The module SHALL have port i_Clock, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The module SHALL have port i_Reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The module SHALL have port i_TX_DV, input, 1 bit: byte-valid request.
REQ-006 The module SHALL have port i_TX_Byte, input, 8 bits: byte to send, sampled only at acceptance.
REQ-007 The module SHALL have port o_TX_Ready, output, 1 bit: high when a new byte can be accepted.
REQ-008 The module SHALL have port o_TX_Serial, output, 1 bit: serial line, idle high; driven from a register.
REQ-009 The module SHALL have port o_TX_Active, output, 1 bit: high while a frame is on the line.
REQ-010 The module SHALL have port o_TX_Done, output, 1 bit: one-cycle pulse at frame completion.

Function
REQ-011 The state machine SHALL have the states IDLE, TX_START_BIT, TX_DATA_BITS, TX_STOP_BIT and CLEANUP; any illegal encoding SHALL return to IDLE on the next cycle.
REQ-012 o_TX_Ready SHALL be 1 only in IDLE.
REQ-013 A byte SHALL be accepted when i_TX_DV=1 and o_TX_Ready=1 in the same cycle.
REQ-014 On acceptance, i_TX_Byte SHALL be latched into an internal shift/hold register, and the state SHALL move to TX_START_BIT on the next edge.
REQ-015 i_TX_DV SHALL be ignored while o_TX_Ready=0; there is no queuing.
REQ-016 Changes on i_TX_Byte after acceptance SHALL NOT affect the frame in progress.
REQ-017 o_TX_Serial SHALL go low on the first cycle after acceptance (latency 1 cycle).
REQ-018 o_TX_Serial SHALL stay low for exactly CLKS_PER_BIT cycles (start bit).
REQ-019 TX_DATA_BITS SHALL send 8 data bits, LSB first, each held for exactly CLKS_PER_BIT cycles.
REQ-020 The bit index SHALL run 0..7, then go to TX_STOP_BIT.
REQ-021 TX_STOP_BIT SHALL drive o_TX_Serial=1 for exactly STOP_BITS*CLKS_PER_BIT cycles, then go to CLEANUP.
REQ-022 The cycle counter SHALL be $clog2(STOP_BITS*CLKS_PER_BIT+1) bits wide.
REQ-023 The cycle counter SHALL reset to 0 at each bit boundary and never wrap within a bit.
REQ-024 CLEANUP SHALL last exactly 1 cycle, with o_TX_Serial=1, o_TX_Done=1 and o_TX_Ready=0; it then goes to IDLE.
REQ-025 o_TX_Done SHALL be 0 in every state except CLEANUP.
REQ-026 o_TX_Active SHALL be 1 in TX_START_BIT, TX_DATA_BITS and TX_STOP_BIT, and 0 in IDLE and CLEANUP.
REQ-027 Total frame length from the first low cycle to CLEANUP entry SHALL be (9+STOP_BITS)*CLKS_PER_BIT cycles.
REQ-028 With back-to-back requests (i_TX_DV held high), the next start bit SHALL begin 2 cycles after the last stop-bit cycle (CLEANUP + IDLE accept cycle); the line stays high in between.
REQ-029 While in IDLE, o_TX_Serial SHALL be 1 whatever i_TX_DV and i_TX_Byte do.

Reset
REQ-030 When i_Reset_n=0 at a rising edge, the next state SHALL be IDLE; the counter, bit index and hold register SHALL be 0; o_TX_Serial=1, o_TX_Ready=1, o_TX_Active=0, o_TX_Done=0.
REQ-031 Reset asserted mid-frame SHALL abort the frame: the line goes high on the next cycle and no o_TX_Done pulse is produced.
REQ-032 i_TX_DV SHALL be ignored in any cycle where i_Reset_n=0.
REQ-033 Reset SHALL have no asynchronous effect; outputs change only on a clock edge.

Verification
REQ-034 The bench SHALL cover basic TX with CLKS_PER_BIT=4, STOP_BITS=1: send 0x55 -> o_TX_Serial bit-by-bit 0,1,0,1,0,1,0,1,0,1, each 4 cycles; o_TX_Done pulses once, 40 cycles after the first low cycle.
REQ-035 The bench SHALL cover LSB order with CLKS_PER_BIT=4: send 0x01 then 0x80 back-to-back with i_TX_DV held -> data patterns 1000_0000 and 0000_0001, and a 2-cycle high gap between frames.
REQ-036 The bench SHALL cover ignored requests: pulse i_TX_DV with 0xFF mid-frame of 0xA3 -> only 0xA3 (bits 1,1,0,0,0,1,0,1) is sent, and o_TX_Ready=0 throughout.
REQ-037 The bench SHALL cover reset mid-frame: assert i_Reset_n=0 during data bit 3 -> next cycle o_TX_Serial=1, o_TX_Ready=1, o_TX_Active=0, no o_TX_Done; a new byte 0x3C then transmits correctly.
REQ-038 The bench SHALL cover two stop bits with STOP_BITS=2, CLKS_PER_BIT=217: send 0x00 -> low for 9*217=1953 cycles, high for 434 cycles, o_TX_Done at cycle 2387.
REQ-039 The bench SHALL cover byte stability: change i_TX_Byte every cycle after accepting 0xC6 -> the transmitted bits match 0xC6.
